// File: rtl/hack_mem_ctrl_pkg.sv
// rtl/hack_mem_ctrl_pkg.sv - shared constants and FSM encoding for the Hack memory controller
// Purpose: memory-mapped I/O addresses and program-load FSM state encoding.
// Ports: none (package).
package hack_mem_ctrl_pkg;

  localparam logic [15:0] KBD_ADDR = 16'h6000;
  localparam logic [15:0] LED_ADDR = 16'h6001;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

endpackage

// File: rtl/hack_mem_ctrl_ram.sv
// rtl/hack_mem_ctrl_ram.sv - word memory with synchronous write and asynchronous read
// Purpose: storage array used for both instruction ROM and data RAM.
// Ports:
//   clk   in  clock
//   we    in  write enable, sampled at posedge
//   waddr in  write index
//   wdata in  write word
//   raddr in  read index
//   rdata out combinational read word
module hack_mem_ctrl_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/hack_mem_ctrl.sv
// rtl/hack_mem_ctrl.sv - Hack CPU memory responder with program loader, keyboard and LED
// Purpose: serves instruction fetch and data access for the Hack CPU, streams a program
//   into instruction ROM while holding the CPU in reset, maps keyboard and LED registers.
// Optional feature macro: RAM_CLEAR_EN (reset sweeps data RAM to zero before loading).
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   pc / instruct          fetch address / rom[pc] (0 outside ROM)
//   addrM, outM, writeM    CPU data address, write data, write strobe
//   inM                    read data for addrM
//   cpu_reset              holds the CPU in reset outside RUN
//   load_valid/ready/data/last  program-load stream
//   kbd                    keyboard code, read at KBD_ADDR
//   led                    LED register, written at LED_ADDR
//   mem_err                sticky flag: CPU wrote an unmapped address in RUN
module hack_mem_ctrl
  import hack_mem_ctrl_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ROM_DEPTH = 16,
  parameter int RAM_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       pc,
  output logic [DATA_W-1:0] instruct,
  input  logic [15:0]       addrM,
  input  logic [DATA_W-1:0] outM,
  input  logic              writeM,
  output logic [DATA_W-1:0] inM,
  output logic              cpu_reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic [DATA_W-1:0] kbd,
  output logic [DATA_W-1:0] led,
  output logic              mem_err
);

  localparam int ROM_AW = $clog2(ROM_DEPTH);
  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam logic [ROM_AW-1:0] WPTR_MAX = ROM_AW'(ROM_DEPTH - 1);

`ifdef RAM_CLEAR_EN
  localparam state_e RESET_ST = ST_CLEAR;
`else
  localparam state_e RESET_ST = ST_LOAD;
`endif

  state_e              state_q, state_d;
  logic [ROM_AW-1:0]   wptr_q, wptr_d;
  logic [DATA_W-1:0]   led_q, led_d;
  logic                mem_err_q, mem_err_d;

  logic                hs;
  logic                run_wr;
  logic                rom_hit, ram_hit, kbd_hit, led_hit;
  logic [DATA_W-1:0]   rom_rdata, ram_rdata;
  logic                ram_we;
  logic [RAM_AW-1:0]   ram_waddr;
  logic [DATA_W-1:0]   ram_wdata;

`ifdef RAM_CLEAR_EN
  logic [RAM_AW-1:0]   clr_q, clr_d;
  logic                clearing;
`endif

  // An index hit requires every address bit above the index width to be zero.
  assign rom_hit = ((pc >> ROM_AW) == 16'd0);
  assign ram_hit = ((addrM >> RAM_AW) == 16'd0);
  assign kbd_hit = (addrM == KBD_ADDR);
  assign led_hit = (addrM == LED_ADDR);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_ST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef RAM_CLEAR_EN
      ST_CLEAR:   if (clr_q == RAM_AW'(RAM_DEPTH - 1)) state_d = ST_LOAD;
`else
      ST_CLEAR:   state_d = ST_LOAD;
`endif
      ST_LOAD:    if (hs && (load_last || wptr_q == WPTR_MAX)) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_RUN;
      ST_RUN:     state_d = ST_RUN;
      default:    state_d = RESET_ST;
    endcase
  end

  // FSM outputs
  always_comb begin
    load_ready = (state_q == ST_LOAD) && !reset;
    cpu_reset  = (state_q != ST_RUN);
    // CPU writes only count in RUN and never on a reset cycle.
    run_wr     = (state_q == ST_RUN) && !reset && writeM;
`ifdef RAM_CLEAR_EN
    clearing   = (state_q == ST_CLEAR);
`endif
  end

  assign hs = load_valid && load_ready;

  always_comb begin
    wptr_d    = wptr_q;
    led_d     = led_q;
    mem_err_d = mem_err_q;
    // Hold at the last slot so the pointer never wraps; the FSM leaves LOAD there.
    if (hs && wptr_q != WPTR_MAX) wptr_d = wptr_q + 1'b1;
    if (run_wr && led_hit) led_d = outM;
    if (run_wr && !ram_hit && !kbd_hit && !led_hit) mem_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q    <= '0;
      led_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      led_q     <= led_d;
      mem_err_q <= mem_err_d;
    end
  end

`ifdef RAM_CLEAR_EN
  always_comb begin
    clr_d = clearing ? clr_q + 1'b1 : clr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_q <= '0;
    end else begin
      clr_q <= clr_d;
    end
  end

  always_comb begin
    ram_we    = run_wr && ram_hit;
    ram_waddr = addrM[RAM_AW-1:0];
    ram_wdata = outM;
    if (clearing) begin
      ram_we    = 1'b1;
      ram_waddr = clr_q;
      ram_wdata = '0;
    end
  end
`else
  always_comb begin
    ram_we    = run_wr && ram_hit;
    ram_waddr = addrM[RAM_AW-1:0];
    ram_wdata = outM;
  end
`endif

  always_comb begin
    inM = '0;
    if (ram_hit)      inM = ram_rdata;
    else if (kbd_hit) inM = kbd;
    else if (led_hit) inM = led_q;
  end

  assign instruct = rom_hit ? rom_rdata : '0;
  assign led      = led_q;
  assign mem_err  = mem_err_q;

  hack_mem_ctrl_ram #(.DATA_W(DATA_W), .DEPTH(ROM_DEPTH)) u_rom (
    .clk   (clk),
    .we    (hs),
    .waddr (wptr_q),
    .wdata (load_data),
    .raddr (pc[ROM_AW-1:0]),
    .rdata (rom_rdata)
  );

  hack_mem_ctrl_ram #(.DATA_W(DATA_W), .DEPTH(RAM_DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (addrM[RAM_AW-1:0]),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_hack_mem_ctrl.sv
// tb/tb_hack_mem_ctrl.sv - directed self-checking bench for hack_mem_ctrl
module tb_hack_mem_ctrl;

`ifdef RAM_CLEAR_EN
  localparam int CLEAR_CYCLES = 16;
  localparam logic [15:0] RAM3_AFTER_RESET = 16'h0000;
  localparam logic [15:0] RAM1_AFTER_RESET = 16'h0000;
`else
  localparam int CLEAR_CYCLES = 0;
  localparam logic [15:0] RAM3_AFTER_RESET = 16'h1111;
  localparam logic [15:0] RAM1_AFTER_RESET = 16'd42;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc = '0, addrM = '0, outM = '0, kbd = '0, load_data = '0;
  logic        writeM = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [15:0] instruct, inM, led;
  logic        cpu_reset, load_ready, mem_err;

  int checks = 0;
  int failures = 0;

  logic [15:0] prog [6];

  hack_mem_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .instruct   (instruct),
    .addrM      (addrM),
    .outM       (outM),
    .writeM     (writeM),
    .inM        (inM),
    .cpu_reset  (cpu_reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .kbd        (kbd),
    .led        (led),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    int n;
    reset = 1'b1; load_valid = 1'b0; writeM = 1'b0;
    tick();
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL %s ready_in_reset got=%b want=0", tag, load_ready); end
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL %s cpu_reset_in_reset got=%b want=1", tag, cpu_reset); end
    checks++; if (led !== 16'h0) begin failures++; $display("FAIL %s led_reset got=%h want=0000", tag, led); end
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL %s mem_err_reset got=%b want=0", tag, mem_err); end
    reset = 1'b0;
    #1;
    n = 0;
    while (load_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++; if (n != CLEAR_CYCLES) begin failures++; $display("FAIL %s cycles_to_load got=%0d want=%0d", tag, n, CLEAR_CYCLES); end
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL %s cpu_reset_in_load got=%b want=1", tag, cpu_reset); end
  endtask

  task automatic stream(input logic [15:0] w, input logic last, input string tag);
    load_valid = 1'b1; load_data = w; load_last = last;
    #1;
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL %s load_ready got=%b want=1", tag, load_ready); end
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic release_check(input string tag);
    #1;
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL %s ready_after_last got=%b want=0", tag, load_ready); end
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL %s cpu_reset_release got=%b want=1", tag, cpu_reset); end
    tick();
    checks++; if (cpu_reset !== 1'b0) begin failures++; $display("FAIL %s cpu_reset_run got=%b want=0", tag, cpu_reset); end
  endtask

  task automatic test_reset;
    do_reset("reset");
  endtask

  task automatic test_full_load;
    for (int i = 0; i < 16; i++) begin
      stream((i == 6) ? 16'h0000 : 16'h1000 + 16'(i), 1'b0, "full_load");
    end
    load_valid = 1'b1; load_data = 16'hBEEF;
    #1;
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL full_ready_word17 got=%b want=0", load_ready); end
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL full_cpu_reset_release got=%b want=1", cpu_reset); end
    tick();
    load_valid = 1'b0;
    checks++; if (cpu_reset !== 1'b0) begin failures++; $display("FAIL full_cpu_reset_run got=%b want=0", cpu_reset); end
    pc = 16'd0; #1;
    checks++; if (instruct !== 16'h1000) begin failures++; $display("FAIL full_rom0 got=%h want=1000", instruct); end
    pc = 16'd15; #1;
    checks++; if (instruct !== 16'h100F) begin failures++; $display("FAIL full_rom15 got=%h want=100f", instruct); end
    addrM = 16'd3; outM = 16'h1111; writeM = 1'b1;
    tick();
    writeM = 1'b0; #1;
    checks++; if (inM !== 16'h1111) begin failures++; $display("FAIL full_ram3 got=%h want=1111", inM); end
  endtask

  task automatic test_reset_mid_load;
    do_reset("mid_load_a");
    stream(16'hA0A0, 1'b0, "mid_load");
    stream(16'hA1A1, 1'b0, "mid_load");
    stream(16'hA2A2, 1'b0, "mid_load");
    do_reset("mid_load_b");
    stream(16'hC0DE, 1'b1, "mid_load_word");
    release_check("mid_load");
    pc = 16'd0; #1;
    checks++; if (instruct !== 16'hC0DE) begin failures++; $display("FAIL mid_rom0 got=%h want=c0de", instruct); end
    pc = 16'd1; #1;
    checks++; if (instruct !== 16'hA1A1) begin failures++; $display("FAIL mid_rom1_persist got=%h want=a1a1", instruct); end
    pc = 16'd3; #1;
    checks++; if (instruct !== 16'h1003) begin failures++; $display("FAIL mid_rom3_persist got=%h want=1003", instruct); end
  endtask

  task automatic test_load_program;
    do_reset("program");
    addrM = 16'd3; outM = 16'h7777; writeM = 1'b1;
    tick();
    addrM = 16'h0020;
    tick();
    writeM = 1'b0; #1;
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL load_write_err got=%b want=0", mem_err); end
    for (int i = 0; i < 6; i++) begin
      stream(prog[i], (i == 5), "program");
    end
    release_check("program");
    for (int i = 0; i < 6; i++) begin
      pc = 16'(i); #1;
      checks++; if (instruct !== prog[i]) begin failures++; $display("FAIL prog_rom%0d got=%h want=%h", i, instruct, prog[i]); end
    end
    pc = 16'd6; #1;
    checks++; if (instruct !== 16'h0000) begin failures++; $display("FAIL prog_rom6 got=%h want=0000", instruct); end
    pc = 16'd16; #1;
    checks++; if (instruct !== 16'h0000) begin failures++; $display("FAIL pc_out_of_range got=%h want=0000", instruct); end
    pc = 16'h8000; #1;
    checks++; if (instruct !== 16'h0000) begin failures++; $display("FAIL pc_high_bit got=%h want=0000", instruct); end
    addrM = 16'd3; #1;
    checks++; if (inM !== RAM3_AFTER_RESET) begin failures++; $display("FAIL load_write_ram3 got=%h want=%h", inM, RAM3_AFTER_RESET); end
  endtask

  task automatic test_ram_write;
    addrM = 16'd0; outM = 16'd42; writeM = 1'b1;
    tick();
    writeM = 1'b0; #1;
    checks++; if (inM !== 16'd42) begin failures++; $display("FAIL ram0_write got=%h want=002a", inM); end
    addrM = 16'd15; outM = 16'hABCD; writeM = 1'b1;
    tick();
    writeM = 1'b0; #1;
    checks++; if (inM !== 16'hABCD) begin failures++; $display("FAIL ram15_write got=%h want=abcd", inM); end
    addrM = 16'd16; #1;
    checks++; if (inM !== 16'h0000) begin failures++; $display("FAIL ram_out_of_range got=%h want=0000", inM); end
  endtask

  task automatic test_io;
    addrM = 16'h6001; outM = 16'h00FF; writeM = 1'b1;
    tick();
    writeM = 1'b0; #1;
    checks++; if (led !== 16'h00FF) begin failures++; $display("FAIL led_write got=%h want=00ff", led); end
    checks++; if (inM !== 16'h00FF) begin failures++; $display("FAIL led_read got=%h want=00ff", inM); end
    kbd = 16'h0041; addrM = 16'h6000; #1;
    checks++; if (inM !== 16'h0041) begin failures++; $display("FAIL kbd_read got=%h want=0041", inM); end
    outM = 16'h1234; writeM = 1'b1;
    tick();
    writeM = 1'b0; #1;
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL kbd_write_err got=%b want=0", mem_err); end
    checks++; if (led !== 16'h00FF) begin failures++; $display("FAIL led_after_kbd_write got=%h want=00ff", led); end
  endtask

  task automatic test_errors;
    addrM = 16'h0030;
    tick(); tick();
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL unmapped_read_err got=%b want=0", mem_err); end
    checks++; if (inM !== 16'h0000) begin failures++; $display("FAIL unmapped_read got=%h want=0000", inM); end
    addrM = 16'h0020; outM = 16'h5555; writeM = 1'b1;
    tick();
    writeM = 1'b0; #1;
    checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL unmapped_write_err got=%b want=1", mem_err); end
    addrM = 16'd0; #1;
    checks++; if (inM !== 16'd42) begin failures++; $display("FAIL ram0_after_unmapped got=%h want=002a", inM); end
    tick(); tick(); tick();
    checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL mem_err_sticky got=%b want=1", mem_err); end
    addrM = 16'd1; outM = 16'd42; writeM = 1'b1;
    tick();
    writeM = 1'b0;
    do_reset("errors");
    stream(16'h0007, 1'b1, "errors");
    release_check("errors");
    addrM = 16'd1; #1;
    checks++; if (inM !== RAM1_AFTER_RESET) begin failures++; $display("FAIL ram1_after_reset got=%h want=%h", inM, RAM1_AFTER_RESET); end
  endtask

  initial begin
    prog[0] = 16'h0002; prog[1] = 16'hEC10; prog[2] = 16'h0003;
    prog[3] = 16'hE090; prog[4] = 16'h0000; prog[5] = 16'hE308;
    test_reset();
    test_full_load();
    test_reset_mid_load();
    test_load_program();
    test_ram_write();
    test_io();
    test_errors();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
